// File: rtl/conv_window_reader.sv
// -----------------------------------------------------------------------------
// conv_window_reader
//
// Read-side sequencer for the 2-D feature-map buffer. Walks every K x K
// window position of the MEM_SIZE x MEM_SIZE buffer in raster order. For each
// position it drives the window address and read enable, registers the four
// packed rows the buffer returns, and offers them downstream on a valid/ready
// handshake.
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   start                pulse; begins a full scan when idle
//   mem_wr_active        buffer writer busy; read enable is suppressed
//   mem_rd_en            buffer read enable
//   mem_add_row/col      top-left address of the window being read
//   mem_data_a..d        buffer window rows 0..3 (combinational from buffer)
//   win_valid/win_ready  downstream handshake
//   win_row0..3          registered window rows, column offset 0 in the MSBs
//   win_pos_row/col      position of the presented window
//   busy                 high whenever a scan is in progress
//   done                 one-cycle pulse after the last window is accepted
// -----------------------------------------------------------------------------
module conv_window_reader #(
    parameter int DW       = 16,
    parameter int K        = 4,
    parameter int OUT_DW   = DW * K,
    parameter int MEM_SIZE = 5,
    parameter int MEM_ADDR = 3,
    parameter int NPOS     = MEM_SIZE - K + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mem_wr_active,
    output logic                mem_rd_en,
    output logic [MEM_ADDR-1:0] mem_add_row,
    output logic [MEM_ADDR-1:0] mem_add_col,
    input  logic [OUT_DW-1:0]   mem_data_a,
    input  logic [OUT_DW-1:0]   mem_data_b,
    input  logic [OUT_DW-1:0]   mem_data_c,
    input  logic [OUT_DW-1:0]   mem_data_d,
    output logic                win_valid,
    input  logic                win_ready,
    output logic [OUT_DW-1:0]   win_row0,
    output logic [OUT_DW-1:0]   win_row1,
    output logic [OUT_DW-1:0]   win_row2,
    output logic [OUT_DW-1:0]   win_row3,
    output logic [MEM_ADDR-1:0] win_pos_row,
    output logic [MEM_ADDR-1:0] win_pos_col,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        VALID = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [MEM_ADDR-1:0] LAST_POS = MEM_ADDR'(NPOS - 1);

    state_t              state;
    logic [MEM_ADDR-1:0] row_cnt;
    logic [MEM_ADDR-1:0] col_cnt;

    // The counters are the read address; they only move on an accepted
    // window, so the address naturally holds while a window is presented.
    assign mem_add_row = row_cnt;
    assign mem_add_col = col_cnt;

    // Read enable must drop in the same cycle the writer claims the buffer,
    // so it is decoded from the state register rather than registered.
    assign mem_rd_en = (state == READ) && !mem_wr_active;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            row_cnt     <= '0;
            col_cnt     <= '0;
            win_row0    <= '0;
            win_row1    <= '0;
            win_row2    <= '0;
            win_row3    <= '0;
            win_pos_row <= '0;
            win_pos_col <= '0;
            win_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        row_cnt <= '0;
                        col_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= READ;
                    end
                end
                READ: begin
                    // A writer stall simply holds us here; nothing is captured.
                    if (!mem_wr_active) begin
                        win_row0    <= mem_data_a;
                        win_row1    <= mem_data_b;
                        win_row2    <= mem_data_c;
                        win_row3    <= mem_data_d;
                        win_pos_row <= row_cnt;
                        win_pos_col <= col_cnt;
                        win_valid   <= 1'b1;
                        state       <= VALID;
                    end
                end
                VALID: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        if (col_cnt != LAST_POS) begin
                            col_cnt <= col_cnt + 1'b1;
                            state   <= READ;
                        end else if (row_cnt != LAST_POS) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + 1'b1;
                            state   <= READ;
                        end else begin
                            // Last window: counters stay at the final
                            // in-range position instead of wrapping past it.
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_reader.sv
// -----------------------------------------------------------------------------
// tb_conv_window_reader
//
// Randomized bench for conv_window_reader. A behavioural buffer model feeds
// the reader; a transaction-level reference (window index, expected rows
// packed from the buffer array) predicts every output.
// -----------------------------------------------------------------------------
module tb_conv_window_reader;

    localparam int DW       = 16;
    localparam int K        = 4;
    localparam int OUT_DW   = DW * K;
    localparam int MEM_SIZE = 5;
    localparam int MEM_ADDR = 3;
    localparam int NPOS     = MEM_SIZE - K + 1;
    localparam int NWIN     = NPOS * NPOS;

    logic                clk;
    logic                reset;
    logic                start;
    logic                mem_wr_active;
    logic                mem_rd_en;
    logic [MEM_ADDR-1:0] mem_add_row;
    logic [MEM_ADDR-1:0] mem_add_col;
    logic [OUT_DW-1:0]   mem_data_a, mem_data_b, mem_data_c, mem_data_d;
    logic                win_valid;
    logic                win_ready;
    logic [OUT_DW-1:0]   win_row0, win_row1, win_row2, win_row3;
    logic [MEM_ADDR-1:0] win_pos_row;
    logic [MEM_ADDR-1:0] win_pos_col;
    logic                busy;
    logic                done;

    conv_window_reader #(
        .DW(DW), .K(K), .OUT_DW(OUT_DW), .MEM_SIZE(MEM_SIZE),
        .MEM_ADDR(MEM_ADDR), .NPOS(NPOS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mem_wr_active(mem_wr_active),
        .mem_rd_en(mem_rd_en), .mem_add_row(mem_add_row), .mem_add_col(mem_add_col),
        .mem_data_a(mem_data_a), .mem_data_b(mem_data_b),
        .mem_data_c(mem_data_c), .mem_data_d(mem_data_d),
        .win_valid(win_valid), .win_ready(win_ready),
        .win_row0(win_row0), .win_row1(win_row1), .win_row2(win_row2), .win_row3(win_row3),
        .win_pos_row(win_pos_row), .win_pos_col(win_pos_col),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural feature-map buffer with a combinational 4x4 read port.
    logic [DW-1:0]     mem [MEM_SIZE][MEM_SIZE];
    logic [OUT_DW-1:0] buf_rows [K];

    always_comb begin
        for (int i = 0; i < K; i++) begin
            buf_rows[i] = '0;
            for (int j = 0; j < K; j++) begin
                buf_rows[i] = buf_rows[i] << DW;
                if (int'(mem_add_row) + i < MEM_SIZE && int'(mem_add_col) + j < MEM_SIZE)
                    buf_rows[i] = buf_rows[i] | OUT_DW'(mem[int'(mem_add_row) + i][int'(mem_add_col) + j]);
            end
        end
    end

    assign mem_data_a = buf_rows[0];
    assign mem_data_b = buf_rows[1];
    assign mem_data_c = buf_rows[2];
    assign mem_data_d = buf_rows[3];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: window k sits at (k / NPOS, k % NPOS); its row i packs
    // mem[r+i][c..c+K-1] with column offset 0 in the most significant word.
    function automatic logic [OUT_DW-1:0] pack_row(input int r, input int c);
        logic [OUT_DW-1:0] v;
        v = '0;
        for (int j = 0; j < K; j++) v = (v << DW) | OUT_DW'(mem[r][c + j]);
        return v;
    endfunction

    int                k;
    bit                exp_valid;
    bit                exp_done;
    bit                in_scan;
    bit                start_hold;
    logic [OUT_DW-1:0] exp_rows [K];

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, mem_rd_en, 0);
        check({tag, "_addr"}, {mem_add_row, mem_add_col}, 0);
        check({tag, "_rows"}, win_row0 | win_row1 | win_row2 | win_row3, 0);
        check({tag, "_pos"}, {win_pos_row, win_pos_col}, 0);
        check({tag, "_ctl"}, {win_valid, busy, done}, 0);
    endtask

    // Runs one scan. already=1 means start was held and the scan launches at
    // the next edge without a fresh pulse. abort_k >= 0 pulls reset while
    // that window is being presented.
    task automatic run_scan(input bit already, input int ready_pct, input int stall_pct,
                            input bit check_lat, input int abort_k, output bit aborted);
        bit finished;
        bit reading;
        int r, c;
        aborted  = 1'b0;
        finished = 1'b0;
        if (!already) begin
            @(negedge clk);
            start         = 1'b1;
            win_ready     = 1'b0;
            mem_wr_active = 1'b0;
        end
        k         = 0;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        in_scan   = 1'b1;
        for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
            @(negedge clk);
            start         = start_hold | ($urandom_range(0, 9) == 0);
            win_ready     = ($urandom_range(0, 99) < ready_pct);
            mem_wr_active = ($urandom_range(0, 99) < stall_pct);
            if (mem_wr_active)
                mem[$urandom_range(0, MEM_SIZE - 1)][$urandom_range(0, MEM_SIZE - 1)] = DW'($urandom);
            #1;
            r       = k / NPOS;
            c       = k % NPOS;
            reading = in_scan && !exp_valid && !exp_done;
            check("done", done, exp_done);
            check("busy", busy, in_scan);
            check("win_valid", win_valid, exp_valid);
            check("mem_rd_en", mem_rd_en, reading && !mem_wr_active);
            if (k < NWIN) check("mem_addr", {mem_add_row, mem_add_col}, {3'(r), 3'(c)});
            if (reading && !mem_wr_active)
                for (int i = 0; i < K; i++) exp_rows[i] = pack_row(r + i, c);
            if (exp_valid || exp_done) begin
                check("win_row0", win_row0, exp_rows[0]);
                check("win_row1", win_row1, exp_rows[1]);
                check("win_row2", win_row2, exp_rows[2]);
                check("win_row3", win_row3, exp_rows[3]);
            end
            if (exp_valid)
                check("win_pos", {win_pos_row, win_pos_col}, {3'(r), 3'(c)});

            if (exp_done) begin
                // done appears 2*NPOS^2 edges after the edge that sampled start.
                if (check_lat) check("scan_latency", cyc - 1, 2 * NWIN);
                in_scan  = 1'b0;
                exp_done = 1'b0;
                finished = 1'b1;
            end else if (exp_valid && k == abort_k) begin
                reset = 1'b0;
                #1;
                check_all_zero("reset_mid_scan");
                in_scan   = 1'b0;
                exp_valid = 1'b0;
                aborted   = 1'b1;
                finished  = 1'b1;
            end else if (exp_valid && win_ready) begin
                k++;
                exp_valid = 1'b0;
                if (k == NWIN) exp_done = 1'b1;
            end else if (reading && !mem_wr_active) begin
                exp_valid = 1'b1;
            end
        end
        check("scan_end", finished, 1'b1);
    endtask

    // One cycle after done: back in idle, last window still held.
    task automatic post_check();
        @(negedge clk);
        if (!start_hold) start = 1'b0;
        win_ready     = $urandom_range(0, 1);
        mem_wr_active = $urandom_range(0, 1);
        #1;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_valid", win_valid, 0);
        check("idle_row0", win_row0, exp_rows[0]);
    endtask

    bit ab;

    initial begin
        reset         = 1'b0;
        start         = 1'b0;
        win_ready     = 1'b0;
        mem_wr_active = 1'b0;
        start_hold    = 1'b0;
        for (int r = 0; r < MEM_SIZE; r++)
            for (int c = 0; c < MEM_SIZE; c++) mem[r][c] = DW'(16 * r + c);

        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset_state");
        @(negedge clk);
        reset = 1'b1;

        // Full scan, ready high, no writer: checks order, contents and latency.
        run_scan(1'b0, 100, 0, 1'b1, -1, ab);
        post_check();
        // Backpressure, writer stalls, then fully random mixes.
        run_scan(1'b0, 30, 0, 1'b0, -1, ab);
        post_check();
        run_scan(1'b0, 100, 40, 1'b0, -1, ab);
        post_check();
        for (int n = 0; n < 6; n++) begin
            run_scan(1'b0, $urandom_range(20, 100), $urandom_range(0, 50), 1'b0, -1, ab);
            post_check();
        end

        // Reset while window (1,0) is presented; no done may follow.
        run_scan(1'b0, 70, 20, 1'b0, NPOS, ab);
        check("abort_taken", ab, 1'b1);
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("held_reset_done", {done, busy, win_valid}, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        // Fresh scan after reset restarts at (0,0).
        run_scan(1'b0, 100, 0, 1'b1, -1, ab);
        post_check();

        // start held high across DONE: a new scan follows the idle cycle.
        start_hold = 1'b1;
        run_scan(1'b0, 100, 0, 1'b1, -1, ab);
        post_check();
        run_scan(1'b1, 100, 0, 1'b1, -1, ab);
        start_hold = 1'b0;
        post_check();
        @(negedge clk);
        #1;
        check("no_restart", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
